plic_gateway: RTL

//   Per-source interrupt gateways for the PLIC, directly upstream of plic_reg and the target arbiters.

---
 rtl/plic_gateway.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/plic_gateway.sv
// ---------------------------------------------------------------------------
// plic_gateway
//   Per-source interrupt gateways sitting in front of plic_reg and the target
//   arbiters. Each raw level IRQ is synchronized, latched as pending, moved to
//   a claimed state owned by the claiming target, and re-armed only when that
//   same target completes it.
//
// Parameters
//   SRC_N        number of sources (1..31); source 0 is reserved and never pends
//   TGT_N        number of targets (1..32)
//   SYNC_STAGES  flops in each irq_src synchronizer chain (1..3)
//
// Ports
//   clk             clock
//   rst             synchronous active-high reset
//   irq_src         raw asynchronous level IRQs, bit k-1 = source k
//   claim_valid     claim strobe; claim_tgt claims source claim_src
//   claim_tgt       claiming target
//   claim_src       source picked by that target's arbiter (0 = none)
//   complete_valid  completion strobe; complete_tgt completes complete_src
//   complete_src    completed source id
//   complete_tgt    completing target
//   int_pending     pending bits, bit 0 tied 0
//   int_claimed     claimed (in service) bits, bit 0 tied 0
//
// Handshake: claim_valid and complete_valid are single-cycle strobes with no
// back-pressure. A strobe that does not match a gateway in the right state is
// dropped silently; the result is visible on the outputs after the same edge.
//
// Debug: each gateway's FSM state is kept in g_src[k-1].state_q (gw_state_e)
// and its owner in g_src[k-1].owner_q for hierarchical observation.
// ---------------------------------------------------------------------------
module plic_gateway #(
  parameter int SRC_N       = 1,
  parameter int TGT_N       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SRC_N-1:0] irq_src,
  input  logic             claim_valid,
  input  logic [4:0]       claim_tgt,
  input  logic [4:0]       claim_src,
  input  logic             complete_valid,
  input  logic [4:0]       complete_src,
  input  logic [4:0]       complete_tgt,
  output logic [SRC_N:0]   int_pending,
  output logic [SRC_N:0]   int_claimed
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_CLAIMED = 2'd2
  } gw_state_e;

  // Six bits so TGT_N = 32 is representable in the comparison.
  localparam logic [5:0] TGT_LIM = 6'(TGT_N);

  // -------------------------------------------------------------------------
  // Synchronizer chains, one per source, all sharing the same stage array.
  // -------------------------------------------------------------------------
  logic [SRC_N-1:0] sync_q [SYNC_STAGES];
  logic [SRC_N-1:0] irq_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= irq_src;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign irq_s = sync_q[SYNC_STAGES-1];

  // A claim from an out-of-range target is discarded for every source.
  logic claim_tgt_ok;
  assign claim_tgt_ok = claim_valid && ({1'b0, claim_tgt} < TGT_LIM);

  logic [SRC_N-1:0] pend_bits;
  logic [SRC_N-1:0] claim_bits;

  // -------------------------------------------------------------------------
  // Per-source gateway FSMs. Gateway g serves source id g+1, so source ids 0
  // and anything above SRC_N never match and are naturally ignored.
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < SRC_N; g++) begin : g_src
    localparam logic [4:0] SRC_ID = 5'(g + 1);

    gw_state_e  state_q, state_d;
    logic [4:0] owner_q, owner_d;
    logic       claim_hit;
    logic       complete_hit;

    assign claim_hit    = claim_tgt_ok && (claim_src == SRC_ID);
    assign complete_hit = complete_valid && (complete_src == SRC_ID)
                          && (complete_tgt == owner_q);

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        owner_q <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
      end
    end

    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      case (state_q)
        ST_IDLE: begin
          if (irq_s[g]) state_d = ST_PENDING;
        end
        // Pending is sticky: a level that drops before the claim is not
        // retracted, the claim still delivers it.
        ST_PENDING: begin
          if (claim_hit) begin
            state_d = ST_CLAIMED;
            owner_d = claim_tgt;
          end
        end
        // The IRQ level is ignored here; re-arm happens from IDLE one edge
        // after the completion, giving the 2-cycle minimum spacing.
        ST_CLAIMED: begin
          if (complete_hit) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    assign pend_bits[g]  = (state_q == ST_PENDING);
    assign claim_bits[g] = (state_q == ST_CLAIMED);
  end

  // Outputs decode directly from state flops, so they are registered.
  assign int_pending = {pend_bits, 1'b0};
  assign int_claimed = {claim_bits, 1'b0};

endmodule
